// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the program loader.
package loader_pkg;
  typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA, CHECK, DONE} state_t;
  localparam logic [7:0] CMD_LOAD_DEF = 8'h4C;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/loader_word_assembler.sv
// loader_word_assembler: packs incoming bytes MSB-first into instruction words.
module loader_word_assembler import loader_pkg::*; #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  complete
);
  logic [DATA_WIDTH-9:0] sr;
  logic [1:0] idx;
  assign word = {sr, byte_in};
  assign complete = en && idx == 2'(BYTES_PER_WORD - 1);
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sr <= '0;
      idx <= '0;
    end else if (en) begin
      sr <= word[DATA_WIDTH-9:0];
      idx <= idx + 2'd1;
    end
  end
endmodule

// File: rtl/program_loader.sv
// program_loader: serial byte stream to instruction-memory writes.
// Define LOADER_CHECKSUM_EN to expect a trailing XOR checksum byte per session.
module program_loader import loader_pkg::*; #(
  parameter int         DATA_WIDTH = 32,
  parameter logic [7:0] CMD_LOAD   = CMD_LOAD_DEF
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic [DATA_WIDTH-1:0] o_instruccion,
  output logic [DATA_WIDTH-1:0] o_address,
  output logic                  o_loading,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);
  state_t state, state_d;
  logic [15:0] n, wcnt;
  logic [DATA_WIDTH-1:0] addr, word;
  logic cmd, data_en, complete, last;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t TAIL = CHECK;
`else
  localparam state_t TAIL = DONE;
`endif
  assign cmd = i_rx_valid && state == IDLE && i_rx_data == CMD_LOAD;
  assign data_en = i_rx_valid && state == DATA;
  assign last = complete && wcnt == n - 16'd1;
  assign o_busy = state != IDLE || o_loading;
  assign o_done = state == DONE;
  loader_word_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
    .clk(i_clock), .rst(i_reset), .clr(cmd), .en(data_en),
    .byte_in(i_rx_data), .word(word), .complete(complete)
  );
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = cmd ? CNT_HI : IDLE;
      CNT_HI:  state_d = i_rx_valid ? CNT_LO : CNT_HI;
      CNT_LO:  state_d = !i_rx_valid ? CNT_LO : ({n[15:8], i_rx_data} == 16'd0 ? TAIL : DATA);
      DATA:    state_d = last ? TAIL : DATA;
      CHECK:   state_d = i_rx_valid ? DONE : CHECK;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
      n <= '0;
      wcnt <= '0;
      addr <= '0;
      o_instruccion <= '0;
      o_address <= '0;
      o_loading <= 1'b0;
    end else begin
      state <= state_d;
      o_loading <= complete;
      if (state == CNT_HI && i_rx_valid) n[15:8] <= i_rx_data;
      if (state == CNT_LO && i_rx_valid) n[7:0] <= i_rx_data;
      if (cmd) begin
        wcnt <= '0;
        addr <= '0;
      end else if (complete) begin
        wcnt <= wcnt + 16'd1;
        addr <= addr + DATA_WIDTH'(BYTES_PER_WORD);
        o_instruccion <= word;
        o_address <= addr;
      end
    end
  end
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] cks;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cks <= '0;
      o_error <= 1'b0;
    end else begin
      if (cmd) begin
        cks <= '0;
        o_error <= 1'b0;
      end else if (data_en) cks <= cks ^ i_rx_data;
      if (state == CHECK && i_rx_valid && i_rx_data != cks) o_error <= 1'b1;
    end
  end
`else
  assign o_error = 1'b0;
`endif
endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction word and address width.
REQ-002 Parameter CMD_LOAD, default 8'h4C, command byte that opens a load session.
REQ-003 Port i_clock, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port i_reset, input, 1, reset; synchronous and active-high.
REQ-005 Port i_rx_data, input, 8, received byte from the serial receiver.
REQ-006 Port i_rx_valid, input, 1, one-cycle strobe marking i_rx_data valid.
REQ-007 Port o_instruccion, output, DATA_WIDTH, assembled instruction word for the fetch-stage instruction memory.
REQ-008 Port o_address, output, DATA_WIDTH, byte address of o_instruccion.
REQ-009 Port o_loading, output, 1, one-cycle write strobe qualifying o_instruccion and o_address.
REQ-010 Port o_busy, output, 1, high while a load session is in progress (pipeline held).
REQ-011 Port o_done, output, 1, one-cycle pulse at session end.
REQ-012 Port o_error, output, 1, sticky checksum-mismatch flag (only meaningful with LOADER_CHECKSUM_EN).

Function
REQ-013 FSM states SHALL be IDLE, CNT_HI, CNT_LO, DATA, CHECK, DONE.
REQ-014 IDLE: valid byte equal to CMD_LOAD -> CNT_HI, clears o_error, word index, byte index; any other byte ignored.
REQ-015 CNT_HI/CNT_LO: next two valid bytes form 16-bit word count N, MSB first; CNT_LO -> DATA, or -> CHECK/DONE if N = 0 (no writes).
REQ-016 DATA: bytes assembled MSB first (first byte -> bits 31:24); 2-bit byte index wraps 3 -> 0.
REQ-017 On the 4th accepted byte, o_instruccion/o_address SHALL be registered and o_loading asserted exactly the following cycle for one cycle.
REQ-018 First word address SHALL be 0; address SHALL increment by 4 per written word, modulo 2^DATA_WIDTH.
REQ-019 After word N is accepted, FSM -> CHECK (if enabled) else DONE; the final o_loading pulse coincides with the first cycle of CHECK/DONE.
REQ-020 DONE lasts one cycle with o_done = 1, then -> IDLE.
REQ-021 o_busy SHALL be 1 in every state except IDLE, and additionally during the final o_loading cycle.
REQ-022 Valid bytes arriving in DONE SHALL be dropped; back-to-back valid bytes on consecutive cycles SHALL all be accepted in CNT_HI/CNT_LO/DATA.
REQ-023 o_instruccion and o_address SHALL hold their last value between strobes.

Reset
REQ-024 i_reset SHALL force IDLE, o_instruccion = 0, o_address = 0, o_loading = 0, o_busy = 0, o_done = 0, o_error = 0, all counters 0.
REQ-025 Reset mid-session SHALL abandon the session with no further o_loading; an assembled but unstrobed word is discarded.

Configuration
REQ-026 Macro LOADER_CHECKSUM_EN defined: CHECK state accepts one byte; if it differs from the XOR of all DATA bytes, o_error = 1 (sticky until next CMD_LOAD), then -> DONE.
REQ-027 Macro LOADER_CHECKSUM_EN undefined: CHECK unreachable, no checksum byte expected, o_error tied 0.

Structure
REQ-028 Shared package loader_pkg SHALL hold the state enumeration, CMD_LOAD default, and BYTES_PER_WORD = 4.
REQ-029 Sub-module loader_word_assembler SHALL contain the byte shift register, byte index and word-complete flag; the FSM, counters and checksum stay in program_loader.

Verification
REQ-030 Bytes 4C 00 01 12 34 56 78 -> single o_loading pulse, o_instruccion = 32'h12345678, o_address = 0, o_done pulse next cycle after.
REQ-031 4C 00 03 + 12 bytes -> three pulses at addresses 0, 4, 8; o_busy high from the byte after 4C through the final pulse.
REQ-032 Bytes 00 FF 4C 00 00 -> no o_loading at all, o_done one cycle after the count LSB, garbage before 4C ignored.
REQ-033 i_reset asserted after 2 data bytes of a 2-word load -> outputs zero next cycle, no strobe; a fresh session then writes from address 0.
REQ-034 With LOADER_CHECKSUM_EN: 4C 00 01 01 02 03 04 + 04 -> o_error 0; same with final byte 05 -> o_error 1, cleared by next 4C.
